// File: rtl/operand_sel_seq.sv
`default_nettype none
// ============================================================================
// operand_sel_seq : registered NCH-way operand selector, ready/valid output,
//                   two-beat swap mode. Optional macro OPMUX_ERR_EN.
// Revision 1.0
// ============================================================================
module operand_sel_seq #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int SEL_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_f,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 swap,
  input  logic                 req_valid,
  output logic                 req_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ready
`ifdef OPMUX_ERR_EN
  ,
  output logic                 sel_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWAP0 = 2'd1,
    S_LAST  = 2'd2
  } state_t;

  localparam int               c_depth = 1 << SEL_W;
  localparam logic [SEL_W-1:0] c_last  = SEL_W'(NCH - 1);

  logic [WIDTH-1:0] ch [c_depth];
  logic             in_range;

  // Unused select codes read as zero so every index of ch is defined.
  generate
    for (genvar gi = 0; gi < c_depth; gi++) begin : g_ch
      if (gi < NCH) begin : g_live
        assign ch[gi] = in_data[gi*WIDTH +: WIDTH];
      end else begin : g_pad
        assign ch[gi] = '0;
      end
    end
    if (NCH == c_depth) begin : g_full
      assign in_range = 1'b1;
    end else begin : g_part
      assign in_range = ({1'b0, sel} < (SEL_W+1)'(NCH));
    end
  endgenerate

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [SEL_W-1:0] idx, idx_nxt;
  logic             accept;
`ifdef OPMUX_ERR_EN
  logic             sel_err_q, sel_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    shadow_d    = shadow_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
`ifdef OPMUX_ERR_EN
    sel_err_d   = 1'b0;
`endif
    req_ready = (state_q == S_IDLE) | (out_valid_q & out_ready & out_last_q);
    accept    = req_valid & req_ready;
    idx       = in_range ? sel : '0;
    // Swap partner wraps at NCH, not at the select-code range.
    idx_nxt   = (idx == c_last) ? '0 : idx + 1'b1;

    if (out_valid_q && out_ready) begin
      if (state_q == S_SWAP0) begin
        out_data_d = shadow_q;
        out_last_d = 1'b1;
        state_d    = S_LAST;
      end else begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        state_d     = S_IDLE;
      end
    end

    // A new request overrides the drain above, giving bubble-free back-to-back beats.
    if (accept) begin
`ifdef OPMUX_ERR_EN
      if (!in_range) begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        sel_err_d   = 1'b1;
        state_d     = S_IDLE;
      end else
`endif
      if (swap) begin
        out_data_d  = ch[idx_nxt];
        shadow_d    = ch[idx];
        out_valid_d = 1'b1;
        out_last_d  = 1'b0;
        state_d     = S_SWAP0;
      end else begin
        out_data_d  = ch[idx];
        out_valid_d = 1'b1;
        out_last_d  = 1'b1;
        state_d     = S_LAST;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q     <= S_IDLE;
      out_data_q  <= '0;
      shadow_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef OPMUX_ERR_EN
      sel_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      shadow_q    <= shadow_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
`ifdef OPMUX_ERR_EN
      sel_err_q   <= sel_err_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
`ifdef OPMUX_ERR_EN
  assign sel_err   = sel_err_q;
`endif

endmodule
`default_nettype wire
